// File: rtl/ram_dumper.sv
// ============================================================================
//  Module   : ram_dumper
//  Brief    : Streams a contiguous byte range out of a synchronous RAM as a
//             txReady-gated byte stream with a one-cycle newData strobe.
//             Optional macro DUMPER_NUL_STOP_EN ends the dump at a 8'h00 byte.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dumper #(
  parameter int addrSize = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addrSize-1:0] startAddr,
  input  logic [addrSize:0]   count,
  output logic                read_rq,
  output logic [addrSize-1:0] addrOut,
  input  logic [7:0]          ramData,
  input  logic                txReady,
  output logic [7:0]          dataOut,
  output logic                newData,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_SEND  = 3'd3,
    S_GAP   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [addrSize-1:0] addr_q, addr_d;
  logic [addrSize:0]   remaining_q, remaining_d;
  logic [7:0]          data_q, data_d;
  logic                read_rq_q, read_rq_d;
  logic                new_data_q, new_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = startAddr;
          remaining_d = count;
          state_d     = (count == '0) ? S_FIN : S_READ;
        end
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: begin
`ifdef DUMPER_NUL_STOP_EN
        if (ramData == 8'h00) begin
          state_d = S_FIN;
        end else begin
          data_d  = ramData;
          state_d = S_SEND;
        end
`else
        data_d  = ramData;
        state_d = S_SEND;
`endif
      end
      S_SEND: begin
        if (txReady) state_d = S_GAP;
      end
      S_GAP: begin
        remaining_d = remaining_q - 1'b1;
        addr_d      = addr_q + 1'b1;
        state_d     = (remaining_q == {{addrSize{1'b0}}, 1'b1}) ? S_FIN : S_READ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so each flop is high exactly
    // while the FSM sits in the corresponding state.
    read_rq_d  = (state_d == S_READ);
    new_data_d = (state_d == S_GAP);
    done_d     = (state_d == S_FIN);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      read_rq_q   <= 1'b0;
      new_data_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      read_rq_q   <= read_rq_d;
      new_data_q  <= new_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign read_rq = read_rq_q;
  assign addrOut = addr_q;
  assign dataOut = data_q;
  assign newData = new_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

`default_nettype wire
